// File: rtl/nios2_mul_seq.sv
// Sequential 32x32 multiplier built from four 16x16 partial products through one registered multiplier.
// Define NIOS2_MUL_SEQ_MULX_EN to support the MULX ops; otherwise they complete at MUL latency flagged illegal.
module nios2_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_illegal,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] src1_q, src2_q;
  logic [63:0] acc;
  logic [1:0]  idx;
  logic [1:0]  last_idx;
  logic        is_mul;
  logic        illegal;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic        mul_vld;
  logic [1:0]  mul_sh;
  logic [1:0]  sh_code;
  logic [63:0] pp_shifted;
  logic [31:0] corr_hi;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign is_mul    = (op_q == 2'b00);

`ifdef NIOS2_MUL_SEQ_MULX_EN
  assign last_idx = is_mul ? 2'd2 : 2'd3;
  assign illegal  = 1'b0;
  // Signed operands contribute -2^32*other to the unsigned product; only the high word changes.
  assign corr_hi  = acc[63:32]
                  - ((op_q[1] && src1_q[31]) ? src2_q : '0)
                  - ((op_q == 2'b11 && src2_q[31]) ? src1_q : '0);
`else
  assign last_idx = 2'd2;
  assign illegal  = !is_mul;
  assign corr_hi  = acc[63:32];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = ISSUE;
      ISSUE: if (idx == last_idx) state_nxt = DRAIN;
      DRAIN: state_nxt = CORR;
      CORR:  state_nxt = DONE;
      DONE:  if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (idx)
      2'd0: begin mul_a = src1_q[15:0];  mul_b = src2_q[15:0];  end
      2'd1: begin mul_a = src1_q[31:16]; mul_b = src2_q[15:0];  end
      2'd2: begin mul_a = src1_q[15:0];  mul_b = src2_q[31:16]; end
`ifdef NIOS2_MUL_SEQ_MULX_EN
      2'd3: begin mul_a = src1_q[31:16]; mul_b = src2_q[31:16]; end
`endif
      default: ;
    endcase
  end

  assign sh_code = (idx == 2'd0) ? 2'd0 : (idx == 2'd3) ? 2'd2 : 2'd1;

  always_comb begin
    case (mul_sh)
      2'd0:    pp_shifted = {32'b0, mul_p};
      2'd1:    pp_shifted = {16'b0, mul_p, 16'b0};
      default: pp_shifted = {mul_p, 32'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      acc         <= '0;
      idx         <= '0;
      mul_p       <= '0;
      mul_vld     <= 1'b0;
      mul_sh      <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      mul_vld <= (state == ISSUE);
      mul_p   <= {16'b0, mul_a} * {16'b0, mul_b};
      mul_sh  <= sh_code;
      if (mul_vld) acc <= acc + pp_shifted;
      case (state)
        IDLE: if (req_valid) begin
          op_q   <= req_op;
          src1_q <= req_src1;
          src2_q <= req_src2;
          acc    <= '0;
          idx    <= '0;
        end
        ISSUE: idx <= idx + 2'd1;
        CORR: begin
          acc[63:32]  <= corr_hi;
          rsp_valid   <= 1'b1;
          rsp_illegal <= illegal;
          rsp_result  <= illegal ? '0 : (is_mul ? acc[31:0] : corr_hi);
        end
        DONE: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mul_seq.sv
// Self-checking bench for nios2_mul_seq: directed vectors, backpressure, reset abort and random ops.
module tb_nios2_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
  logic        busy;

  int tests = 0;
  int fails = 0;

  nios2_mul_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] ea, eb, prod;
`ifndef NIOS2_MUL_SEQ_MULX_EN
    if (op != 2'b00) return 32'h0;
`endif
    ea   = op[1] ? {{32{a[31]}}, a} : {32'b0, a};
    eb   = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
    prod = ea * eb;
    return (op == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic int model_latency(input logic [1:0] op);
`ifdef NIOS2_MUL_SEQ_MULX_EN
    return (op == 2'b00) ? 6 : 7;
`else
    return 6;
`endif
  endfunction

  function automatic logic model_illegal(input logic [1:0] op);
`ifdef NIOS2_MUL_SEQ_MULX_EN
    return 1'b0;
`else
    return op != 2'b00;
`endif
  endfunction

  // Called at posedge+#1 with the DUT idle; returns idle one cycle after the handshake.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall);
    int lat;
    logic [31:0] held;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_src1 = $urandom; req_src2 = $urandom;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    chk($sformatf("latency op%0d", op), lat, model_latency(op));
    chk($sformatf("result op%0d %h*%h", op, a, b), rsp_result, model_result(op, a, b));
    chk("illegal", {31'b0, rsp_illegal}, {31'b0, model_illegal(op)});
    held = rsp_result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_result", rsp_result, held);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_hs_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    run_op(2'b00, 32'h00010003, 32'h00020005, 0);
    chk("mul_vector_const", rsp_result, 32'h000B000F);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2'b11, 32'hFFFFFFFF, 32'h00000002, 0);
    run_op(2'b10, 32'hFFFFFFFF, 32'h00000002, 0);
    run_op(2'b11, 32'h80000000, 32'h80000000, 0);
    run_op(2'b00, 32'hDEADBEEF, 32'h12345678, 3);
    run_op(2'b00, 32'h0000FFFF, 32'hFFFF0000, 0);
    run_op(2'b01, 32'h00000000, 32'h12345678, 1);

    // Abort a MULXUU at cycle 3 with a concurrent (ignored) request.
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'hFFFFFFFF; req_src2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    run_op(2'b00, 32'h00010003, 32'h00020005, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a[31] = 1'b1;
      if (i % 3 == 0) b[31] = 1'b1;
      run_op(2'($urandom), a, b, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios2_mul_seq.md
NIOS2_MUL_SEQ -- requirements
Module: nios2_mul_seq

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: req_valid  in  1  request present.
REQ-004 SHALL have ports: req_ready  out  1  block accepts a request this cycle.
REQ-005 SHALL have ports: req_op  in  2  00 MUL (low 32), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS (high 32).
REQ-006 SHALL have ports: req_src1, req_src2  in  32 each  operands.
REQ-007 SHALL have ports: rsp_valid  out  1  result present.
REQ-008 SHALL have ports: rsp_ready  in  1  consumer takes result.
REQ-009 SHALL have ports: rsp_result  out  32  product word.
REQ-010 SHALL have ports: rsp_illegal  out  1  op not supported in this build.
REQ-011 SHALL have ports: busy  out  1  state != IDLE.

Function
REQ-012 SHALL accept a request on a cycle where req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-013 SHALL capture op and both operands at acceptance; later input changes SHALL have no effect.
REQ-014 SHALL use states IDLE -> ISSUE -> DRAIN -> CORR -> DONE -> IDLE.
REQ-015 SHALL compute the product from unsigned 16x16 partial products through one internal multiplier with a 1-cycle registered output:
- pp0 = lo1*lo2 at shift 0
- pp1 = hi1*lo2 at shift 16
- pp2 = lo1*hi2 at shift 16
- pp3 = hi1*hi2 at shift 32
REQ-016 ISSUE SHALL issue one partial product per cycle: pp0..pp2 for MUL (3 cycles); pp0..pp3 for MULX ops (4 cycles).
REQ-017 SHALL add each multiplier output, shifted, into a 64-bit accumulator (cleared at acceptance) on the cycle after issue; DRAIN SHALL absorb the last product.
REQ-018 CORR SHALL, modulo 2^32 on the high word:
- subtract src2 when src1 is treated as signed and src1[31]=1
- subtract src1 when op=MULXSS and src2[31]=1
- make no change for MUL and MULXUU
REQ-019 DONE SHALL drive rsp_valid=1, with rsp_result = accumulator[31:0] for MUL and [63:32] for MULX.
REQ-020 SHALL place rsp_valid at cycle 6 after acceptance (cycle 0) for MUL and at cycle 7 for MULX ops.
REQ-021 SHALL hold rsp_valid, rsp_result and rsp_illegal stable while rsp_valid=1 and rsp_ready=0.
REQ-022 SHALL go DONE -> IDLE on rsp_valid&rsp_ready; the earliest next acceptance SHALL be the following cycle.
REQ-023 All output registers SHALL be registered; req_ready and busy SHALL be decoded from the state register only.

Reset
REQ-024 On a clock edge with reset=1 the block SHALL enter IDLE, zero the accumulator and set rsp_valid=0, rsp_result=0, rsp_illegal=0, busy=0, req_ready=1 from the next cycle.
REQ-025 Reset in any non-IDLE state SHALL discard the operation in flight; no response SHALL ever appear for it.
REQ-026 req_valid SHALL be ignored in every cycle where reset=1.

Configuration
REQ-027 Macro NIOS2_MUL_SEQ_MULX_EN defined: all four ops SHALL be supported and rsp_illegal SHALL be constant 0.
REQ-028 Macro NIOS2_MUL_SEQ_MULX_EN undefined: the pp3 path and CORR arithmetic SHALL be omitted; a MULX op SHALL be accepted and SHALL complete at MUL latency (cycle 6) with rsp_result=0 and rsp_illegal=1. MUL SHALL be unaffected.

Verification
REQ-029 MUL, src1=0x00010003, src2=0x00020005 -> rsp_result=0x000B000F, rsp_valid at cycle 6.
REQ-030 MULXUU, src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 0xFFFFFFFE at cycle 7.
REQ-031 Signed ops:
- MULXSS, 0xFFFFFFFF and 0x00000002 -> 0xFFFFFFFF
- MULXSU, same operands -> 0xFFFFFFFF
- MULXSS, 0x80000000 and 0x80000000 -> 0x40000000
REQ-032 Response backpressure: rsp_ready=0 for 3 cycles after rsp_valid -> result stable, req_ready=0; a back-to-back request is accepted exactly one cycle after the response handshake.
REQ-033 Reset pulse at cycle 3 of a MULXUU -> no rsp_valid afterwards; busy=0 and req_ready=1 on the next cycle; a following MUL completes correctly.
REQ-034 Build without NIOS2_MUL_SEQ_MULX_EN, MULXUU request -> rsp_illegal=1, rsp_result=0 at cycle 6; a subsequent MUL returns rsp_illegal=0.
